sample_buffer_reader: RTL



---
 rtl/sample_buffer_reader_pkg.sv | 21 ++
 rtl/sample_buffer_reader_tap_shift_register.sv | 23 ++
 rtl/sample_buffer_reader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sample_buffer_reader_pkg.sv
// Shared constants and FSM encoding for the interpolation sample buffer path.
package sample_buffer_reader_pkg;

  localparam int unsigned DATA_W = 11;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned TAPS   = 8;

  // Cycle counter must reach TAPS+2 during a full fill.
  localparam int unsigned CNT_W     = $clog2(TAPS + 3);
  localparam int unsigned FILL_DONE = TAPS + 2;
  localparam int unsigned STEP_DONE = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    STEP = 2'd2,
    HOLD = 2'd3
  } state_e;

endpackage

// File: rtl/sample_buffer_reader_tap_shift_register.sv
// Tap window shift register: new samples enter the top tap, older ones move toward tap 0.
module tap_shift_register
  import sample_buffer_reader_pkg::*;
#(
  parameter int unsigned W = DATA_W,
  parameter int unsigned N = TAPS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_en,
  input  logic signed [W-1:0] din,
  output logic [N*W-1:0]      taps_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps_out <= '0;
    end else if (shift_en) begin
      taps_out <= {din, taps_out[N*W-1:W]};
    end
  end

endmodule

// File: rtl/sample_buffer_reader.sv
// Read side of the interpolation sample buffer: fetches a TAPS-sample window
// from the circular RAM and slides it by one sample per advance request.
module sample_buffer_reader
  import sample_buffer_reader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic                     advance,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [DATA_W-1:0] rd_data,
  output logic [TAPS*DATA_W-1:0]   taps_out,
  output logic                     valid,
  output logic                     busy
);

  state_e              state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [ADDR_W-1:0]   ptr_q, ptr_n;
  logic [ADDR_W-1:0]   rd_addr_n;
  logic                rd_en_n, valid_n, busy_n;
  logic                rd_en_d;

  // Registered state, outputs and read-data-valid tracker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      rd_en_d <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      ptr_q   <= ptr_n;
      rd_en   <= rd_en_n;
      rd_addr <= rd_addr_n;
      valid   <= valid_n;
      busy    <= busy_n;
      rd_en_d <= rd_en;
    end
  end

  // Next-state and next-output logic; cnt_q counts cycles spent in FILL/STEP.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    ptr_n     = ptr_q;
    rd_en_n   = 1'b0;
    rd_addr_n = rd_addr;
    valid_n   = valid;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_n   = FILL;
          cnt_n     = CNT_W'(1);
          ptr_n     = base_addr;
          rd_en_n   = 1'b1;
          rd_addr_n = base_addr;
          valid_n   = 1'b0;
        end
      end
      FILL: begin
        cnt_n = cnt_q + CNT_W'(1);
        if (cnt_q < CNT_W'(TAPS)) begin
          rd_en_n   = 1'b1;
          rd_addr_n = rd_addr + ADDR_W'(1);
        end
        if (cnt_q == CNT_W'(FILL_DONE)) begin
          state_n = HOLD;
          cnt_n   = '0;
          valid_n = 1'b1;
        end
      end
      STEP: begin
        cnt_n = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STEP_DONE)) begin
          state_n = HOLD;
          cnt_n   = '0;
          ptr_n   = ptr_q + ADDR_W'(1);
          valid_n = 1'b1;
        end
      end
      HOLD: begin
        // START takes priority over ADVANCE.
        if (start) begin
          state_n   = FILL;
          cnt_n     = CNT_W'(1);
          ptr_n     = base_addr;
          rd_en_n   = 1'b1;
          rd_addr_n = base_addr;
          valid_n   = 1'b0;
        end else if (advance) begin
          state_n   = STEP;
          cnt_n     = CNT_W'(1);
          rd_en_n   = 1'b1;
          rd_addr_n = ptr_q + ADDR_W'(TAPS);
          valid_n   = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        valid_n = 1'b0;
      end
    endcase

    busy_n = (state_n == FILL) || (state_n == STEP);
  end

  tap_shift_register #(
    .W (DATA_W),
    .N (TAPS)
  ) u_taps (
    .clk      (clk),
    .rst      (rst),
    .shift_en (rd_en_d),
    .din      (rd_data),
    .taps_out (taps_out)
  );

endmodule
